// File: rtl/arf_error_monitor_if.sv
// Handshake and statistics bundle for arf_error_monitor.
// max_abs_err exists only when ARF_MAX_ERR_EN is defined.
interface arf_error_monitor_if #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
);
   logic                            start;
   logic [CNT_W-1:0]                n_samples;
   logic                            in_valid;
   logic                            in_ready;
   logic [DATA_W-1:0]               out_approx;
   logic [DATA_W-1:0]               out_acc;
   logic                            busy;
   logic                            done;
   logic [CNT_W-1:0]                count;
   logic [DATA_W+CNT_W:0]           err_sum;
   logic [2*(DATA_W+1)+CNT_W-1:0]   sq_err_sum;
   logic [DATA_W+CNT_W-1:0]         abs_res_sum;
`ifdef ARF_MAX_ERR_EN
   logic [DATA_W:0]                 max_abs_err;

   modport master (
      output start, n_samples, in_valid, out_approx, out_acc,
      input  in_ready, busy, done, count, err_sum, sq_err_sum, abs_res_sum, max_abs_err
   );
   modport slave (
      input  start, n_samples, in_valid, out_approx, out_acc,
      output in_ready, busy, done, count, err_sum, sq_err_sum, abs_res_sum, max_abs_err
   );
`else
   modport master (
      output start, n_samples, in_valid, out_approx, out_acc,
      input  in_ready, busy, done, count, err_sum, sq_err_sum, abs_res_sum
   );
   modport slave (
      input  start, n_samples, in_valid, out_approx, out_acc,
      output in_ready, busy, done, count, err_sum, sq_err_sum, abs_res_sum
   );
`endif
endinterface

// File: rtl/arf_error_monitor.sv
// Error statistics between approximate and accurate filter outputs, 3-stage pipeline.
// Optional running max |e| output enabled by defining ARF_MAX_ERR_EN.
module arf_error_monitor #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   arf_error_monitor_if.slave    bus
);
   localparam int EW     = DATA_W + 1;
   localparam int PROD_W = 2 * EW;
   localparam int ERR_W  = EW + CNT_W;
   localparam int SQ_W   = PROD_W + CNT_W;
   localparam int ABS_W  = DATA_W + CNT_W;

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
   state_t state, state_nx;

   logic [CNT_W-1:0]  n_lat;
   logic [CNT_W-1:0]  accepted;
   logic              ready;
   logic              xfer;
   logic              start_ok;
   logic              done_q;

   logic              v1, v2;
   logic [EW-1:0]     e1, e2;
   logic [DATA_W-1:0] a1, a2;
   logic [PROD_W-1:0] sq2;

   logic [EW-1:0]     e_in;
   logic [DATA_W-1:0] a_in;
   logic [PROD_W-1:0] e_ext;
   logic [PROD_W-1:0] sq_in;

   logic [CNT_W-1:0]  count_q;
   logic [ERR_W-1:0]  err_q;
   logic [SQ_W-1:0]   sq_q;
   logic [ABS_W-1:0]  abs_q;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE, DONE: if (bus.start) state_nx = (bus.n_samples == '0) ? DONE : ACCUM;
         // the last sample in stage 2 lands in the sums on the same edge DONE is entered
         ACCUM:      if (accepted == n_lat && !v1) state_nx = DONE;
         default:    state_nx = IDLE;
      endcase
   end

   always_comb begin
      start_ok = bus.start && (state != ACCUM);
      ready    = (state == ACCUM) && (accepted < n_lat);
      xfer     = bus.in_valid && ready;
   end

   always_comb begin
      e_in  = {bus.out_approx[DATA_W-1], bus.out_approx} - {bus.out_acc[DATA_W-1], bus.out_acc};
      a_in  = bus.out_acc[DATA_W-1] ? (~bus.out_acc + DATA_W'(1)) : bus.out_acc;
      e_ext = {{EW{e1[EW-1]}}, e1};
      sq_in = e_ext * e_ext;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         done_q <= 1'b0;
      end else begin
         state  <= state_nx;
         done_q <= (state_nx == DONE) && ((state != DONE) || start_ok);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_lat    <= '0;
         accepted <= '0;
      end else if (start_ok) begin
         n_lat    <= bus.n_samples;
         accepted <= '0;
      end else if (xfer) begin
         accepted <= accepted + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1  <= 1'b0;
         v2  <= 1'b0;
         e1  <= '0;
         a1  <= '0;
         e2  <= '0;
         a2  <= '0;
         sq2 <= '0;
      end else begin
         v1 <= xfer;
         v2 <= v1;
         if (xfer) begin
            e1 <= e_in;
            a1 <= a_in;
         end
         if (v1) begin
            e2  <= e1;
            a2  <= a1;
            sq2 <= sq_in;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         err_q   <= '0;
         sq_q    <= '0;
         abs_q   <= '0;
      end else if (start_ok) begin
         count_q <= '0;
         err_q   <= '0;
         sq_q    <= '0;
         abs_q   <= '0;
      end else if (v2) begin
         count_q <= count_q + CNT_W'(1);
         err_q   <= err_q + {{CNT_W{e2[EW-1]}}, e2};
         sq_q    <= sq_q + {{CNT_W{1'b0}}, sq2};
         abs_q   <= abs_q + {{CNT_W{1'b0}}, a2};
      end
   end

`ifdef ARF_MAX_ERR_EN
   logic [EW-1:0] e_mag;
   logic [EW-1:0] max_q;

   // |e| never reaches 2^DATA_W, so negation fits in EW bits
   always_comb e_mag = e2[EW-1] ? (~e2 + EW'(1)) : e2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         max_q <= '0;
      else if (start_ok)
         max_q <= '0;
      else if (v2 && (e_mag > max_q))
         max_q <= e_mag;
   end

   assign bus.max_abs_err = max_q;
`endif

   assign bus.in_ready    = ready;
   assign bus.busy        = (state == ACCUM);
   assign bus.done        = done_q;
   assign bus.count       = count_q;
   assign bus.err_sum     = err_q;
   assign bus.sq_err_sum  = sq_q;
   assign bus.abs_res_sum = abs_q;

endmodule

// File: tb/tb_arf_error_monitor.sv
// Directed and random checks of arf_error_monitor statistics, handshake and done timing.
module tb_arf_error_monitor;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   logic [31:0] qa[$];
   logic [31:0] qb[$];

   arf_error_monitor_if #(.DATA_W(32), .CNT_W(16)) bus();
   arf_error_monitor #(.DATA_W(32), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_start(input logic [15:0] n);
      @(negedge clk); bus.start = 1'b1; bus.n_samples = n;
      @(negedge clk); bus.start = 1'b0;
   endtask

   // Drives qa/qb pairs; reports stalls, in_ready after last, done latency and pulse count.
   task automatic feed(input int gap_pct, input int start_at, output int stalls,
                       output logic rdy_after, output int lat, output int pulses);
      int guard;
      stalls = 0;
      for (int i = 0; i < qa.size(); i++) begin
         if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
            @(negedge clk); bus.in_valid = 1'b0; bus.start = 1'b0;
         end
         @(negedge clk);
         bus.in_valid = 1'b1; bus.out_approx = qa[i]; bus.out_acc = qb[i];
         bus.start = (i == start_at);
         if (i == start_at) bus.n_samples = 16'd9;
         guard = 0;
         while (!bus.in_ready && guard < 10) begin stalls++; @(negedge clk); guard++; end
      end
      lat = 0; pulses = 0; rdy_after = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 1) begin rdy_after = bus.in_ready; bus.in_valid = 1'b0; bus.start = 1'b0; end
         if (bus.done) begin pulses++; if (lat == 0) lat = k; end
      end
   endtask

   task automatic test_reset();
      bus.start = 1'b0; bus.n_samples = '0; bus.in_valid = 1'b0; bus.out_approx = '0; bus.out_acc = '0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0d exp 0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %0d exp 0", bus.done); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0d exp 0", bus.in_ready); end
      checks++; if (bus.count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.count); end
      checks++; if (bus.err_sum !== 49'd0 || bus.sq_err_sum !== 82'd0 || bus.abs_res_sum !== 48'd0) begin
         errors++; $display("FAIL reset_sums got %0h %0h %0h exp 0 0 0", bus.err_sum, bus.sq_err_sum, bus.abs_res_sum); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %0d exp 0", bus.busy); end
   endtask

   task automatic test_basic();
      int st, lat, pl; logic ra;
      qa = '{32'd10, -32'sd5, 32'd0};
      qb = '{32'd7,  -32'sd5, 32'd4};
      do_start(16'd3);
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %0d exp 1", bus.busy); end
      feed(0, -1, st, ra, lat, pl);
      checks++; if (st !== 0) begin errors++; $display("FAIL basic_stalls got %0d exp 0", st); end
      checks++; if (lat !== 3) begin errors++; $display("FAIL basic_done_latency got %0d exp 3", lat); end
      checks++; if (pl !== 1) begin errors++; $display("FAIL basic_done_pulses got %0d exp 1", pl); end
      checks++; if (bus.err_sum !== 49'(-1)) begin errors++; $display("FAIL basic_err_sum got %0h exp %0h", bus.err_sum, 49'(-1)); end
      checks++; if (bus.sq_err_sum !== 82'd25) begin errors++; $display("FAIL basic_sq_err_sum got %0d exp 25", bus.sq_err_sum); end
      checks++; if (bus.abs_res_sum !== 48'd16) begin errors++; $display("FAIL basic_abs_res_sum got %0d exp 16", bus.abs_res_sum); end
      checks++; if (bus.count !== 16'd3) begin errors++; $display("FAIL basic_count got %0d exp 3", bus.count); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %0d exp 0", bus.busy); end
`ifdef ARF_MAX_ERR_EN
      checks++; if (bus.max_abs_err !== 33'd4) begin errors++; $display("FAIL basic_max_abs_err got %0d exp 4", bus.max_abs_err); end
`endif
   endtask

   task automatic test_zero_samples();
      @(negedge clk); bus.start = 1'b1; bus.n_samples = 16'd0;
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL zero_in_ready_pre got %0d exp 0", bus.in_ready); end
      @(negedge clk); bus.start = 1'b0;
      checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL zero_done got %0d exp 1", bus.done); end
      checks++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL zero_ready_busy got %0d %0d exp 0 0", bus.in_ready, bus.busy); end
      checks++; if (bus.count !== 16'd0) begin errors++; $display("FAIL zero_count got %0d exp 0", bus.count); end
      checks++; if (bus.err_sum !== 49'd0 || bus.sq_err_sum !== 82'd0 || bus.abs_res_sum !== 48'd0) begin
         errors++; $display("FAIL zero_sums got %0h %0h %0h exp 0 0 0", bus.err_sum, bus.sq_err_sum, bus.abs_res_sum); end
      @(negedge clk);
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL zero_done_single got %0d exp 0", bus.done); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL zero_in_ready_post got %0d exp 0", bus.in_ready); end
   endtask

   task automatic test_extremes();
      int st, lat, pl; logic ra;
      qa = '{32'h7FFF_FFFF};
      qb = '{32'h8000_0000};
      do_start(16'd1);
      feed(0, -1, st, ra, lat, pl);
      checks++; if (lat !== 3 || pl !== 1) begin errors++; $display("FAIL ext_done got lat=%0d pulses=%0d exp 3 1", lat, pl); end
      checks++; if (bus.err_sum !== 49'h0_FFFF_FFFF) begin errors++; $display("FAIL ext_err_sum got %0h exp ffffffff", bus.err_sum); end
      checks++; if (bus.sq_err_sum !== 82'hFFFF_FFFE_0000_0001) begin errors++; $display("FAIL ext_sq_err_sum got %0h exp fffffffe00000001", bus.sq_err_sum); end
      checks++; if (bus.abs_res_sum !== 48'h8000_0000) begin errors++; $display("FAIL ext_abs_res_sum got %0h exp 80000000", bus.abs_res_sum); end
`ifdef ARF_MAX_ERR_EN
      checks++; if (bus.max_abs_err !== 33'h0_FFFF_FFFF) begin errors++; $display("FAIL ext_max_abs_err got %0h exp ffffffff", bus.max_abs_err); end
`endif
   endtask

   task automatic test_back_to_back();
      int st, lat, pl; logic ra;
      qa = '{32'd1, 32'd3, -32'sd7, 32'd100};
      qb = '{32'd2, -32'sd3, 32'd0, 32'd50};
      do_start(16'd4);
      feed(0, -1, st, ra, lat, pl);
      checks++; if (st !== 0) begin errors++; $display("FAIL b2b_stalls got %0d exp 0", st); end
      checks++; if (ra !== 1'b0) begin errors++; $display("FAIL b2b_ready_after_last got %0d exp 0", ra); end
      checks++; if (lat !== 3 || pl !== 1) begin errors++; $display("FAIL b2b_done got lat=%0d pulses=%0d exp 3 1", lat, pl); end
      checks++; if (bus.err_sum !== 49'd48) begin errors++; $display("FAIL b2b_err_sum got %0d exp 48", bus.err_sum); end
      checks++; if (bus.sq_err_sum !== 82'd2586) begin errors++; $display("FAIL b2b_sq_err_sum got %0d exp 2586", bus.sq_err_sum); end
      checks++; if (bus.abs_res_sum !== 48'd55) begin errors++; $display("FAIL b2b_abs_res_sum got %0d exp 55", bus.abs_res_sum); end
      checks++; if (bus.count !== 16'd4) begin errors++; $display("FAIL b2b_count got %0d exp 4", bus.count); end
`ifdef ARF_MAX_ERR_EN
      checks++; if (bus.max_abs_err !== 33'd50) begin errors++; $display("FAIL b2b_max_abs_err got %0d exp 50", bus.max_abs_err); end
`endif
   endtask

   task automatic test_start_in_accum();
      int st, lat, pl; logic ra;
      qa = '{32'd2, -32'sd3, 32'd6};
      qb = '{32'd1, 32'd4, 32'd6};
      do_start(16'd3);
      feed(0, 1, st, ra, lat, pl);
      checks++; if (st !== 0 || ra !== 1'b0) begin errors++; $display("FAIL ign_handshake got stalls=%0d ready=%0d exp 0 0", st, ra); end
      checks++; if (lat !== 3 || pl !== 1) begin errors++; $display("FAIL ign_done got lat=%0d pulses=%0d exp 3 1", lat, pl); end
      checks++; if (bus.count !== 16'd3) begin errors++; $display("FAIL ign_count got %0d exp 3", bus.count); end
      checks++; if (bus.err_sum !== 49'(-6)) begin errors++; $display("FAIL ign_err_sum got %0h exp %0h", bus.err_sum, 49'(-6)); end
      checks++; if (bus.sq_err_sum !== 82'd50 || bus.abs_res_sum !== 48'd11) begin
         errors++; $display("FAIL ign_sq_abs got %0d %0d exp 50 11", bus.sq_err_sum, bus.abs_res_sum); end
   endtask

   task automatic test_reset_mid_run();
      int st, lat, pl; logic ra;
      qa = '{32'd5, -32'sd2};
      qb = '{32'd1, 32'd3};
      do_start(16'd5);
      feed(0, -1, st, ra, lat, pl);
      checks++; if (bus.count !== 16'd2 || bus.busy !== 1'b1 || pl !== 0) begin
         errors++; $display("FAIL mid_pre got count=%0d busy=%0d pulses=%0d exp 2 1 0", bus.count, bus.busy, pl); end
      checks++; if (bus.err_sum !== 49'(-1)) begin errors++; $display("FAIL mid_pre_err_sum got %0h exp %0h", bus.err_sum, 49'(-1)); end
      @(negedge clk); rst_n = 1'b0;
      #1;
      checks++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.done !== 1'b0) begin
         errors++; $display("FAIL mid_async got busy=%0d ready=%0d done=%0d exp 0 0 0", bus.busy, bus.in_ready, bus.done); end
      checks++; if (bus.count !== 16'd0 || bus.err_sum !== 49'd0 || bus.sq_err_sum !== 82'd0 || bus.abs_res_sum !== 48'd0) begin
         errors++; $display("FAIL mid_async_sums got %0d %0h %0h %0h exp 0 0 0 0", bus.count, bus.err_sum, bus.sq_err_sum, bus.abs_res_sum); end
      @(negedge clk); rst_n = 1'b1; bus.in_valid = 1'b1; bus.out_approx = 32'd9; bus.out_acc = 32'd1;
      repeat (3) @(negedge clk);
      checks++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.count !== 16'd0) begin
         errors++; $display("FAIL mid_idle got busy=%0d ready=%0d count=%0d exp 0 0 0", bus.busy, bus.in_ready, bus.count); end
      bus.in_valid = 1'b0;
   endtask

   task automatic test_random();
      int st, lat, pl; logic ra;
      longint a, b, e, ae, em, am;
      logic [81:0] sqm;
      logic [32:0] mx;
      logic [31:0] va, vb;
      qa.delete(); qb.delete();
      em = 0; am = 0; sqm = '0; mx = '0;
      for (int i = 0; i < 1000; i++) begin
         va = $urandom; vb = $urandom;
         case ($urandom_range(9))
            0: va = 32'h8000_0000;
            1: va = 32'h7FFF_FFFF;
            2: vb = 32'h8000_0000;
            3: vb = 32'h7FFF_FFFF;
            default: ;
         endcase
         qa.push_back(va); qb.push_back(vb);
         a = longint'($signed(va)); b = longint'($signed(vb));
         e = a - b;
         ae = (e < 0) ? -e : e;
         em += e;
         am += (b < 0) ? -b : b;
         sqm += 82'(ae) * 82'(ae);
         if (33'(ae) > mx) mx = 33'(ae);
      end
      do_start(16'd1000);
      feed(20, -1, st, ra, lat, pl);
      checks++; if (st !== 0 || lat !== 3 || pl !== 1) begin
         errors++; $display("FAIL rnd_handshake got stalls=%0d lat=%0d pulses=%0d exp 0 3 1", st, lat, pl); end
      checks++; if (bus.count !== 16'd1000) begin errors++; $display("FAIL rnd_count got %0d exp 1000", bus.count); end
      checks++; if (bus.err_sum !== 49'(em)) begin errors++; $display("FAIL rnd_err_sum got %0h exp %0h", bus.err_sum, 49'(em)); end
      checks++; if (bus.sq_err_sum !== sqm) begin errors++; $display("FAIL rnd_sq_err_sum got %0h exp %0h", bus.sq_err_sum, sqm); end
      checks++; if (bus.abs_res_sum !== 48'(am)) begin errors++; $display("FAIL rnd_abs_res_sum got %0h exp %0h", bus.abs_res_sum, 48'(am)); end
`ifdef ARF_MAX_ERR_EN
      checks++; if (bus.max_abs_err !== mx) begin errors++; $display("FAIL rnd_max_abs_err got %0h exp %0h", bus.max_abs_err, mx); end
`endif
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_samples();
      test_extremes();
      test_back_to_back();
      test_start_in_accum();
      test_reset_mid_run();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
